pwm_deadtime_gen: RTL and testbench
===================================

Name: pwm_deadtime_gen

Overview:
- Downstream consumer of the 16-bit PWM carrier/sync timer.
- Compares the timer's `carrier` against a double-buffered compare value and produces a reference PWM.
- Converts that reference into a complementary high-side/low-side gate pair with programmable dead time and a latched trip shutdown.
- Compare and dead-time shadow registers transfer to the active registers on the timer's `sync` pulse, so duty updates land only at carrier min/max.

Parameters:
- PWMWIDTH, 16, width of carrier and compare values.
- DTWIDTH, 10, width of the dead-time count (clock cycles).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  output enable; 0 forces both gates off.
- carrier  in  PWMWIDTH  carrier from the PWM timer.
- sync  in  1  shadow-load strobe from the PWM timer.
- cmp_in  in  PWMWIDTH  new compare value.
- dt_in  in  DTWIDTH  new dead time in clk cycles.
- wr  in  1  writes cmp_in/dt_in into the shadow registers.
- load_imm  in  1  1 = active registers track shadow every cycle; 0 = update only on sync.
- polarity  in  1  0 = ref high when carrier < cmp; 1 = inverted.
- trip  in  1  synchronous fault input, active high.
- pwm_h  out  1  high-side gate, registered.
- pwm_l  out  1  low-side gate, registered.
- trip_flag  out  1  latched trip status.
- cmp_active  out  PWMWIDTH  compare value in use.

Behaviour:
- Reset (rstn=0, async): pwm_h=0, pwm_l=0, trip_flag=0, cmp_shadow=0, cmp_active=0, dt_shadow=0, dt_active=0, dt_cnt=0, state=S_OFF.
- Shadow: wr=1 at an edge loads cmp_shadow<=cmp_in and dt_shadow<=dt_in.
- Transfer: active<=shadow at an edge where (load_imm=1) or (sync=1).
  - If wr and sync occur on the same edge, active gets the OLD shadow; the new value transfers on the next sync.
- ref = (carrier < cmp_active) XOR polarity, combinational and unsigned.
  - cmp_active=0 gives ref=polarity.
  - cmp_active > max carrier gives ref=~polarity.
- FSM states: S_OFF, S_DT_H, S_HIGH, S_DT_L, S_LOW. Outputs are registered decodes of the next state: pwm_h=1 only in S_HIGH, pwm_l=1 only in S_LOW. pwm_h and pwm_l are never 1 together.
- Priority per edge: trip > en=0 > normal transitions.
- Normal transitions:
  - S_OFF: if en=1 and trip_flag=0, go to S_HIGH if ref=1, else S_LOW. No dead band, since both gates were already off.
  - S_LOW with ref=1: if dt_active=0 go to S_HIGH; else go to S_DT_H with dt_cnt<=dt_active.
  - S_HIGH with ref=0: if dt_active=0 go to S_LOW; else go to S_DT_L with dt_cnt<=dt_active.
  - S_DT_H: dt_cnt decrements each cycle. When dt_cnt=1, go to S_HIGH. If ref returns to 0 first, go to S_LOW (abort; H never turned on).
  - S_DT_L: symmetric to S_DT_H.
- Dead-band length: both gates are low for exactly dt_active cycles, sampled at DT entry. A dt_active change during a DT state does not affect the running count.
- Latency: ref change at carrier presented before edge k gives gate change at edge k. Rising edge of the incoming gate follows at edge k+dt_active.
- Trip:
  - trip=1 at an edge sets state to S_OFF and both gates to 0 on that edge, and sets trip_flag=1.
  - trip_flag clears only when en=0 and trip=0 at an edge.
  - While trip_flag=1, S_OFF is held even if en=1.
- en=0: go to S_OFF at the next edge, from any state.
- Reset mid-operation: all outputs go 0 immediately (async), with no dead-band sequencing.
- Carrier wrap (up mode, carrier->0) is handled like any other ref change.

Test Plan:
1. Basic dead band: PWMWIDTH=16, timer up-count countmax=100, wr cmp_in=40 dt_in=5, load_imm=0, en=1, polarity=0.
   - After the first sync: pwm_h high for carrier 0..39 minus dead band.
   - Both low for exactly 5 clk after each ref edge.
   - pwm_l high otherwise.
   - pwm_h&pwm_l never 1.
2. Shadow timing: mid-period wr cmp_in=70.
   - cmp_active stays 40 until the edge where sync=1, then 70.
   - With load_imm=1, cmp_active=70 the cycle after wr.
3. Zero dead time: dt_in=0, cmp=50.
   - Gates swap on the same edge, with no both-off cycle, at carrier=50 and at wrap.
4. DT abort: dt=20, cmp so ref high for only 3 cycles.
   - S_DT_H is entered, ref falls, FSM returns to S_LOW.
   - pwm_h never asserts; pwm_l returns 1 three cycles after falling.
5. Trip: trip pulse 1 clk while pwm_h=1.
   - Both gates 0 on that edge; trip_flag=1.
   - Outputs stay 0 with en=1.
   - en=0 for one edge, then en=1: trip_flag=0 and outputs resume per ref.
6. Async reset: drop rstn between edges while pwm_l=1.
   - pwm_l=0 and cmp_active=0 immediately; all outputs stay 0 after rstn releases until en=1 and cmp is rewritten.

Source files
------------

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM gate driver: compares the timer carrier against a double-buffered
// compare value and inserts programmable dead time between high- and low-side gates.
module pwm_deadtime_gen #(
  parameter int unsigned PWMWIDTH = 16,
  parameter int unsigned DTWIDTH  = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [PWMWIDTH-1:0] carrier,
  input  logic                sync,
  input  logic [PWMWIDTH-1:0] cmp_in,
  input  logic [DTWIDTH-1:0]  dt_in,
  input  logic                wr,
  input  logic                load_imm,
  input  logic                polarity,
  input  logic                trip,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                trip_flag,
  output logic [PWMWIDTH-1:0] cmp_active
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DT_H,
    S_HIGH,
    S_DT_L,
    S_LOW
  } state_t;

  state_t               state, state_nxt;
  logic [PWMWIDTH-1:0]  cmp_shadow;
  logic [DTWIDTH-1:0]   dt_shadow, dt_active, dt_cnt, dt_cnt_nxt;
  logic                 trip_flag_nxt;
  logic                 ref_pwm;

  assign ref_pwm = (carrier < cmp_active) ^ polarity;

  // Transfer samples the shadow before this edge's write, so a write coinciding
  // with sync only reaches the active registers on the following sync.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_shadow <= '0;
      dt_shadow  <= '0;
      cmp_active <= '0;
      dt_active  <= '0;
    end else begin
      if (wr) begin
        cmp_shadow <= cmp_in;
        dt_shadow  <= dt_in;
      end
      if (load_imm || sync) begin
        cmp_active <= cmp_shadow;
        dt_active  <= dt_shadow;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    dt_cnt_nxt    = dt_cnt;
    trip_flag_nxt = trip_flag;
    if (trip) begin
      state_nxt     = S_OFF;
      trip_flag_nxt = 1'b1;
    end else if (!en) begin
      state_nxt     = S_OFF;
      trip_flag_nxt = 1'b0;
    end else if (trip_flag) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:  state_nxt = ref_pwm ? S_HIGH : S_LOW;
        S_LOW: begin
          if (ref_pwm) begin
            if (dt_active == '0) begin
              state_nxt = S_HIGH;
            end else begin
              state_nxt  = S_DT_H;
              dt_cnt_nxt = dt_active;
            end
          end
        end
        S_HIGH: begin
          if (!ref_pwm) begin
            if (dt_active == '0) begin
              state_nxt = S_LOW;
            end else begin
              state_nxt  = S_DT_L;
              dt_cnt_nxt = dt_active;
            end
          end
        end
        // An aborted dead band falls straight back: the incoming gate never turned on.
        S_DT_H: begin
          if (!ref_pwm)                      state_nxt  = S_LOW;
          else if (dt_cnt <= DTWIDTH'(1))    state_nxt  = S_HIGH;
          else                               dt_cnt_nxt = dt_cnt - DTWIDTH'(1);
        end
        S_DT_L: begin
          if (ref_pwm)                       state_nxt  = S_HIGH;
          else if (dt_cnt <= DTWIDTH'(1))    state_nxt  = S_LOW;
          else                               dt_cnt_nxt = dt_cnt - DTWIDTH'(1);
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_OFF;
      dt_cnt    <= '0;
      trip_flag <= 1'b0;
      pwm_h     <= 1'b0;
      pwm_l     <= 1'b0;
    end else begin
      state     <= state_nxt;
      dt_cnt    <= dt_cnt_nxt;
      trip_flag <= trip_flag_nxt;
      pwm_h     <= (state_nxt == S_HIGH);
      pwm_l     <= (state_nxt == S_LOW);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed scoreboard bench for pwm_deadtime_gen: stimulus pushes hand-derived gate and
// compare expectations; a monitor pops one per clock edge (or async probe) and compares.
module tb_pwm_deadtime_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic [15:0] carrier = '0;
  logic        sync = 1'b0;
  logic [15:0] cmp_in = '0;
  logic [9:0]  dt_in = '0;
  logic        wr = 1'b0;
  logic        load_imm = 1'b0;
  logic        polarity = 1'b0;
  logic        trip = 1'b0;
  logic        pwm_h, pwm_l, trip_flag;
  logic [15:0] cmp_active;
  logic        probe = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        h;
    logic        l;
    logic        tf;
    logic [15:0] cmp;
    string       nm;
  } exp_t;

  exp_t sb[$];

  pwm_deadtime_gen #(.PWMWIDTH(16), .DTWIDTH(10)) dut (
    .clk(clk), .rstn(rstn), .en(en), .carrier(carrier), .sync(sync),
    .cmp_in(cmp_in), .dt_in(dt_in), .wr(wr), .load_imm(load_imm),
    .polarity(polarity), .trip(trip), .pwm_h(pwm_h), .pwm_l(pwm_l),
    .trip_flag(trip_flag), .cmp_active(cmp_active)
  );

  always #5 clk = ~clk;

  // Drives carrier/sync for one cycle and records what the outputs must be after the next edge.
  task automatic step(input logic [15:0] c, input logic s, input logic eh, input logic el,
                      input logic etf, input logic [15:0] ecmp, input string nm);
    exp_t e;
    carrier = c;
    sync    = s;
    e.h = eh; e.l = el; e.tf = etf; e.cmp = ecmp; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or posedge probe);
      #1;
      checks++;
      if (pwm_h && pwm_l) begin
        failures++;
        $display("FAIL overlap: got h=%0b l=%0b, want never both 1 (t=%0t)", pwm_h, pwm_l, $time);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({pwm_h, pwm_l, trip_flag, cmp_active} !== {e.h, e.l, e.tf, e.cmp}) begin
          failures++;
          $display("FAIL %s: got h=%0b l=%0b trip_flag=%0b cmp_active=%0d, want h=%0b l=%0b trip_flag=%0b cmp_active=%0d (carrier=%0d t=%0t)",
                   e.nm, pwm_h, pwm_l, trip_flag, cmp_active, e.h, e.l, e.tf, e.cmp, carrier, $time);
        end
      end
    end
  end

  initial begin : stim
    #2 rstn = 1'b0;
    @(negedge clk);
    step(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "reset");
    rstn = 1'b1;

    // Basic dead band: cmp 40, dt 5, up-count 0..100, sync at carrier 0
    wr = 1'b1; cmp_in = 16'd40; dt_in = 10'd5;
    step(16'd50, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "t1_shadow_only");
    wr = 1'b0; en = 1'b1;
    for (int c = 0; c <= 100; c++)
      step(16'(c), c == 0, (c >= 6 && c <= 39), (c == 0 || c >= 45), 1'b0, 16'd40, "t1_first_period");
    for (int c = 0; c <= 100; c++)
      step(16'(c), c == 0, (c >= 5 && c <= 39), (c >= 45), 1'b0, 16'd40, "t1_steady");

    // Shadow timing: write 70 mid-period, active changes only at sync
    for (int c = 0; c <= 100; c++) begin
      wr = (c == 20); cmp_in = 16'd70;
      step(16'(c), c == 0, (c >= 5 && c <= 39), (c >= 45), 1'b0, 16'd40, "t2_hold");
    end
    wr = 1'b0;
    for (int c = 0; c <= 100; c++)
      step(16'(c), c == 0, (c >= 5 && c <= 69), (c >= 75), 1'b0, 16'd70, "t2_after_sync");

    en = 1'b0; wr = 1'b1; cmp_in = 16'd55;
    step(16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd70, "t2_wr_with_sync");
    wr = 1'b0;
    step(16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd55, "t2_next_sync");
    load_imm = 1'b1; wr = 1'b1; cmp_in = 16'd50; dt_in = 10'd0;
    step(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd55, "t2_imm_wr");
    wr = 1'b0;
    step(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50, "t2_imm_next");

    // Zero dead time: gates swap on the same edge at carrier 50 and at wrap
    en = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c <= 100; c++)
        step(16'(c), c == 0, (c < 50), (c >= 50), 1'b0, 16'd50, "t3_zero_dt");

    // Dead-band abort: dt 20, ref high only for carrier 0..2
    wr = 1'b1; cmp_in = 16'd3; dt_in = 10'd20;
    step(16'd100, 1'b0, 1'b0, 1'b1, 1'b0, 16'd50, "t4_setup");
    wr = 1'b0;
    step(16'd100, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, "t4_load");
    for (int c = 0; c <= 10; c++)
      step(16'(c), 1'b0, 1'b0, (c >= 3), 1'b0, 16'd3, "t4_abort");

    // Trip while high-side is on
    wr = 1'b1; cmp_in = 16'd50; dt_in = 10'd2;
    step(16'd10, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, "t5_setup");
    wr = 1'b0;
    step(16'd10, 1'b0, 1'b0, 1'b1, 1'b0, 16'd50, "t5_load");
    step(16'd11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50, "t5_dt1");
    step(16'd12, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50, "t5_dt2");
    step(16'd13, 1'b0, 1'b1, 1'b0, 1'b0, 16'd50, "t5_high");
    trip = 1'b1;
    step(16'd14, 1'b0, 1'b0, 1'b0, 1'b1, 16'd50, "t5_trip");
    trip = 1'b0;
    for (int c = 15; c <= 17; c++)
      step(16'(c), 1'b0, 1'b0, 1'b0, 1'b1, 16'd50, "t5_hold_off");
    en = 1'b0;
    step(16'd18, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50, "t5_clear");
    en = 1'b1;
    step(16'd19, 1'b0, 1'b1, 1'b0, 1'b0, 16'd50, "t5_resume");
    step(16'd20, 1'b0, 1'b1, 1'b0, 1'b0, 16'd50, "t5_resume_hold");

    // Async reset while low-side is on
    step(16'd60, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50, "t6_dt1");
    step(16'd61, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50, "t6_dt2");
    step(16'd62, 1'b0, 1'b0, 1'b1, 1'b0, 16'd50, "t6_low");
    step(16'd63, 1'b0, 1'b0, 1'b1, 1'b0, 16'd50, "t6_low_hold");
    #2;
    en = 1'b0; rstn = 1'b0;
    sb.push_back('{h: 1'b0, l: 1'b0, tf: 1'b0, cmp: 16'd0, nm: "t6_async"});
    probe = 1'b1;
    #2 probe = 1'b0;
    @(negedge clk);
    step(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "t6_in_reset");
    rstn = 1'b1;
    step(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "t6_released");
    step(16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "t6_released_hold");
    wr = 1'b1; cmp_in = 16'd40; dt_in = 10'd0;
    step(16'd10, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "t6_rewrite");
    wr = 1'b0; en = 1'b1;
    step(16'd10, 1'b0, 1'b0, 1'b1, 1'b0, 16'd40, "t6_enable");
    step(16'd11, 1'b0, 1'b1, 1'b0, 1'b0, 16'd40, "t6_run");

    // Inverted polarity
    polarity = 1'b1;
    step(16'd12, 1'b0, 1'b0, 1'b1, 1'b0, 16'd40, "t7_pol_low");
    step(16'd45, 1'b0, 1'b1, 1'b0, 1'b0, 16'd40, "t7_pol_high");

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
